mdu_ctrl: RTL

- Multiply/divide unit with its sequencing controller, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and holds the HI/LO registers.
- Models multi-cycle latency with a busy/count state machine, so hazard logic can stall HI/LO-touching instructions in D.
- Honours the exception/interrupt request `req`: a flushed E instruction must not start an operation or write HI/LO.

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 73 +++++++
 rtl/mdu_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and default latencies.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Purely combinational multiply/divide datapath producing {hi,lo} and a
// divide-by-zero flag for the controller.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] digit1,
  input  logic [31:0] digit2,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [31:0] sdiv_den;
  logic [31:0] udiv_den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{digit1[31]}}, digit1} * {{32{digit2[31]}}, digit2};
  assign prod_u = {32'd0, digit1} * {32'd0, digit2};

  assign abs1     = mag32(digit1);
  assign abs2     = mag32(digit2);
  assign sdiv_den = (abs2 == 32'd0) ? 32'd1 : abs2;
  assign udiv_den = (digit2 == 32'd0) ? 32'd1 : digit2;

  assign q_mag = abs1 / sdiv_den;
  assign r_mag = abs1 % sdiv_den;
  assign q_u   = digit1 / udiv_den;
  assign r_u   = digit1 % udiv_den;

  // Sign-magnitude division; 0x80000000 / -1 yields q=0x80000000, r=0.
  always_comb begin
    if (digit1 == 32'h8000_0000 && digit2 == 32'hFFFF_FFFF) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = (digit1[31] ^ digit2[31]) ? (32'd0 - q_mag) : q_mag;
      r_s = digit1[31] ? (32'd0 - r_mag) : r_mag;
    end
  end

  // Select the result for the requested long operation.
  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        result   = {r_s, q_s};
        div_zero = (digit2 == 32'd0);
      end
      MDU_DIVU: begin
        result   = {r_u, q_u};
        div_zero = (digit2 == 32'd0);
      end
      default: begin
        result   = 64'd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: busy/count FSM, shadow result
// registers and the architectural HI/LO pair.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] digit1,
  input  logic [31:0] digit2,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      shadow_hi;
  logic [31:0]      shadow_lo;
  logic             skip_write;
  logic [63:0]      calc_result;
  logic             calc_div_zero;
  logic             accept;

  mdu_calc u_calc (
    .op       (mdu_op),
    .digit1   (digit1),
    .digit2   (digit2),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  assign accept = start & ~req & (state == ST_IDLE);

  // FSM, counter, shadow capture and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      count      <= '0;
      shadow_hi  <= 32'd0;
      shadow_lo  <= 32'd0;
      skip_write <= 1'b0;
      hi_out     <= 32'd0;
      lo_out     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (accept) begin
            case (mdu_op)
              MDU_MULT, MDU_MULTU: begin
                {shadow_hi, shadow_lo} <= calc_result;
                skip_write <= 1'b0;
                count      <= CNT_W'(MULT_CYCLES);
                state      <= ST_BUSY;
                busy       <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                {shadow_hi, shadow_lo} <= calc_result;
                skip_write <= calc_div_zero;
                count      <= CNT_W'(DIV_CYCLES);
                state      <= ST_BUSY;
                busy       <= 1'b1;
              end
              MDU_MTHI: hi_out <= digit1;
              MDU_MTLO: lo_out <= digit1;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!skip_write) begin
              hi_out <= shadow_hi;
              lo_out <= shadow_lo;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // mfhi/mflo read path; not gated by req.
  always_comb begin
    rd_data = 32'd0;
    if (start) begin
      case (mdu_op)
        MDU_MFHI: rd_data = hi_out;
        MDU_MFLO: rd_data = lo_out;
        default:  rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

endmodule
